// File: rtl/axis_flit_receiver.sv
// axis_flit_receiver: NoC egress endpoint. Flits from the router's ejection
// port are buffered in a small credit-governed FIFO. They are then reassembled,
// SERIALIZATION_FACTOR flits at a time, into one AXI-Stream beat. One credit
// is returned upstream for every flit popped from the FIFO.
module axis_flit_receiver #(
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int DEST_WIDTH           = 6,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]   data_in,
  input  logic [DEST_WIDTH-1:0]                         dest_in,
  input  logic                                          is_tail_in,
  input  logic                                          send_in,
  output logic                                          credit_out,
  output logic                                          axis_tvalid,
  input  logic                                          axis_tready,
  output logic [TDATA_WIDTH-1:0]                        axis_tdata,
  output logic                                          axis_tlast,
  output logic [DEST_WIDTH-1:0]                         axis_tdest,
  output logic                                          overflow_err,
  output logic                                          protocol_err
);

  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int SF         = SERIALIZATION_FACTOR;
  localparam int DEPTH      = FLIT_BUFFER_DEPTH;
  localparam int IDX_W      = $clog2(SF);
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int ENTRY_W    = FLIT_WIDTH + DEST_WIDTH + 1;

  typedef enum logic {S_COLLECT = 1'b0, S_PRESENT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ENTRY_W-1:0]      fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TDATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [DEST_WIDTH-1:0]   tdest_q, tdest_d;
  logic                    tlast_q, tlast_d;
  logic                    credit_q;
  logic                    overflow_q, overflow_d;
  logic                    protocol_q, protocol_d;

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    wr_en;
  logic                    last_slot;
  logic [ENTRY_W-1:0]      rd_entry;
  logic [FLIT_WIDTH-1:0]   rd_data;
  logic [DEST_WIDTH-1:0]   rd_dest;
  logic                    rd_tail;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign last_slot  = (idx_q == IDX_W'(SF - 1));
  // A write into a full FIFO is still accepted when a pop frees a slot in the same cycle
  assign wr_en      = send_in && (!fifo_full || pop);

  assign rd_entry = fifo_mem_q[rd_ptr_q];
  assign rd_data  = rd_entry[ENTRY_W-1 -: FLIT_WIDTH];
  assign rd_dest  = rd_entry[DEST_WIDTH:1];
  assign rd_tail  = rd_entry[0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_COLLECT;
    else        state_q <= state_d;
  end

  // FSM next-state logic: leave COLLECT on the last flit of a beat, PRESENT on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (pop && last_slot)  state_d = S_PRESENT;
      S_PRESENT: if (axis_tready)       state_d = S_COLLECT;
      default:                          state_d = S_COLLECT;
    endcase
  end

  // FSM outputs: beat valid in PRESENT; pop in COLLECT, or on the handshake cycle in PRESENT
  always_comb begin
    axis_tvalid = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_COLLECT: pop = !fifo_empty;
      S_PRESENT: begin
        axis_tvalid = 1'b1;
        pop         = axis_tready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // FIFO pointer/occupancy and assembly next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    tdata_d    = tdata_q;
    tdest_d    = tdest_q;
    tlast_d    = tlast_q;
    overflow_d = overflow_q;
    protocol_d = protocol_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (send_in && !wr_en) overflow_d = 1'b1;
    if (pop) begin
      tdata_d[int'(idx_q) * FLIT_WIDTH +: FLIT_WIDTH] = rd_data;
      if (idx_q == '0) tdest_d = rd_dest;
      if (last_slot) begin
        tlast_d = rd_tail;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        if (rd_tail) protocol_d = 1'b1;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      tdata_q    <= '0;
      tdest_q    <= '0;
      tlast_q    <= 1'b0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      protocol_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      tdata_q    <= tdata_d;
      tdest_q    <= tdest_d;
      tlast_q    <= tlast_d;
      credit_q   <= pop;
      overflow_q <= overflow_d;
      protocol_q <= protocol_d;
    end
  end

  // FIFO storage; an entry is only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem_q[wr_ptr_q] <= {data_in, dest_in, is_tail_in};
  end

  assign credit_out   = credit_q;
  assign axis_tdata   = tdata_q;
  assign axis_tdest   = tdest_q;
  assign axis_tlast   = tlast_q;
  assign overflow_err = overflow_q;
  assign protocol_err = protocol_q;

endmodule

// File: tb/tb_axis_flit_receiver.sv
// Testbench for axis_flit_receiver: a credit-tracking upstream driver pushes
// expected beats into a scoreboard; a monitor pops them on each handshake.
`timescale 1ns/1ps
module tb_axis_flit_receiver;

  localparam int TW = 512, SF = 4, FW = 128, DW = 6, DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [FW-1:0]   data_in = '0;
  logic [DW-1:0]   dest_in = '0;
  logic            is_tail_in = 1'b0;
  logic            send_in = 1'b0;
  logic            credit_out;
  logic            axis_tvalid;
  logic            axis_tready = 1'b0;
  logic [TW-1:0]   axis_tdata;
  logic            axis_tlast;
  logic [DW-1:0]   axis_tdest;
  logic            overflow_err;
  logic            protocol_err;

  axis_flit_receiver #(
    .TDATA_WIDTH(TW), .SERIALIZATION_FACTOR(SF), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
    .axis_tlast(axis_tlast), .axis_tdest(axis_tdest),
    .overflow_err(overflow_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TW-1:0] d;
    logic [DW-1:0] dest;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    hs_log[$];
  int    assertions = 0;
  int    failures = 0;
  int    sent = 0;
  int    rcvd = 0;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    assertions++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [FW-1:0] fl(input int b, input int i);
    return {16'(b), 16'(i), 32'hDEAD0000 ^ 32'(b * 4 + i), 64'(b * 1000 + i)};
  endfunction

  function automatic logic [TW-1:0] beat_data(input int b);
    logic [TW-1:0] d;
    for (int i = 0; i < SF; i++) d[i*FW +: FW] = fl(b, i);
    return d;
  endfunction

  // Monitor: counts credit pulses and checks each handshaked beat against the scoreboard
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) rcvd = 0;
      else if (credit_out) rcvd++;
      if (rst_n && axis_tvalid && axis_tready) begin
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat_tdata", axis_tdata, e.d);
          check("beat_tdest", TW'(axis_tdest), TW'(e.dest));
          check("beat_tlast", TW'(axis_tlast), TW'(e.last));
        end
      end
    end
  end

  // Sends one flit once a credit is available; returns #1 after the accepting edge
  task automatic send_flit(input logic [FW-1:0] d, input logic [DW-1:0] de, input logic t);
    int w = 0;
    while ((DEPTH - sent + rcvd) <= 0 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 200) timeout_fail("credit_wait");
    data_in = d; dest_in = de; is_tail_in = t; send_in = 1'b1;
    sent++;
    @(posedge clk); #1;
    send_in = 1'b0; is_tail_in = 1'b0;
  endtask

  // Sends SF flits of beat b; only flit 0 carries the beat's dest
  task automatic send_beat(input int b, input logic [DW-1:0] de, input logic [SF-1:0] tm);
    beat_t e;
    for (int i = 0; i < SF; i++) send_flit(fl(b, i), de ^ DW'(i), tm[i]);
    e.d = beat_data(b); e.dest = de; e.last = tm[SF-1];
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk); #1; w++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail({name, "_drain"});
      exp_q.delete();
    end
    repeat (4) begin @(posedge clk); #1; end
    check({name, "_credits"}, TW'(rcvd), TW'(sent));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sent = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tdata"}, axis_tdata, '0);
    check({name, "_tdest"}, TW'(axis_tdest), '0);
    check({name, "_ctrl"}, TW'({axis_tvalid, axis_tlast, credit_out, overflow_err, protocol_err}), '0);
  endtask

  // Two beats into a stalled sink; leaves the FIFO full with beat b1 presented
  task automatic fill_two(input int b1, input int b2, input logic [DW-1:0] de);
    axis_tready = 1'b0;
    send_beat(b1, de, 4'b0000);
    send_beat(b2, de + DW'(1), 4'b1000);
  endtask

  initial begin
    int r, t0, pre;
    logic [SF-1:0] m;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single beat, latency and credit timing
    axis_tready = 1'b1;
    send_beat(1, 6'h15, 4'b1000);
    check("t1_tvalid_early", TW'(axis_tvalid), TW'(0));
    @(posedge clk); #1;
    check("t1_tvalid_t5", TW'(axis_tvalid), TW'(1));
    check("t1_credit_t5", TW'(credit_out), TW'(1));
    wait_drain("t1");

    // 2: stalled sink, full FIFO, then release
    pre = rcvd;
    fill_two(2, 3, 6'h2A);
    for (int k = 0; k < 6; k++) begin
      check("t2_hold_tdata", axis_tdata, beat_data(2));
      check("t2_hold_credit", TW'(credit_out), TW'(0));
      @(posedge clk); #1;
    end
    check("t2_credits_while_full", TW'(rcvd - pre), TW'(4));
    hs_log.delete();
    r = cyc;
    axis_tready = 1'b1;
    wait_drain("t2");
    check("t2_hs_count", TW'(hs_log.size()), TW'(2));
    if (hs_log.size() == 2)
      check("t2_second_beat_by_sf1", TW'(hs_log[1] - r <= SF + 1), TW'(1));
    check("t2_credits_total", TW'(rcvd - pre), TW'(8));

    // 6: continuous stream, credit-paced upstream, one beat per SF cycles
    hs_log.delete();
    axis_tready = 1'b1;
    for (int b = 0; b < 10; b++) send_beat(10 + b, DW'(b), 4'b1000);
    wait_drain("t6");
    check("t6_hs_count", TW'(hs_log.size()), TW'(10));
    for (int k = 1; k < hs_log.size(); k++)
      check("t6_beat_spacing", TW'(hs_log[k] - hs_log[k-1]), TW'(SF));
    check("t6_no_errors", TW'({overflow_err, protocol_err}), '0);

    // 3: overflow while full
    pre = rcvd;
    fill_two(30, 31, 6'h07);
    data_in = fl(99, 0); dest_in = 6'h3F; is_tail_in = 1'b1; send_in = 1'b1;
    @(posedge clk); #1;
    send_in = 1'b0; is_tail_in = 1'b0;
    check("t3_overflow_err", TW'(overflow_err), TW'(1));
    repeat (3) begin @(posedge clk); #1; end
    check("t3_no_extra_credit", TW'(rcvd - pre), TW'(4));
    axis_tready = 1'b1;
    wait_drain("t3");
    check("t3_credits_total", TW'(rcvd - pre), TW'(8));

    // 4: early tail on flit 1
    check("t4_perr_before", TW'(protocol_err), TW'(0));
    m = 4'b1010;
    send_beat(40, 6'h33, m);
    wait_drain("t4");
    check("t4_protocol_err", TW'(protocol_err), TW'(1));

    // 5: reset mid-beat discards partial flits
    axis_tready = 1'b1;
    send_flit(fl(50, 0), 6'h11, 1'b0);
    send_flit(fl(50, 1), 6'h11, 1'b0);
    do_reset();
    check_all_zero("t5_after_reset");
    t0 = cyc;
    send_beat(51, 6'h22, 4'b1000);
    wait_drain("t5");
    check("t5_flags_clear", TW'({overflow_err, protocol_err}), '0);
    check("t5_cycle_sanity", TW'(cyc > t0), TW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
